div_hilo_unit: RTL
==================

DIV_HILO_UNIT -- requirements
Module: div_hilo_unit

Interface
REQ-001 Parameter DIV_CYCLES, default 4, meaning number of wait cycles given to the combinational divider path (legal range 1..15).
REQ-002 Port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  request a signed divide of dividend by divisor.
REQ-005 Port dividend  input  32  signed dividend, sampled when start is accepted.
REQ-006 Port divisor  input  32  signed divisor, sampled when start is accepted.
REQ-007 Port hi_we  input  1  direct write of wr_data into HI (move-to-HI).
REQ-008 Port lo_we  input  1  direct write of wr_data into LO (move-to-LO).
REQ-009 Port wr_data  input  32  data for direct HI/LO writes.
REQ-010 Port busy  output  1  high while a divide is in flight.
REQ-011 Port done  output  1  one-cycle pulse when a divide completes or is rejected.
REQ-012 Port div_by_zero  output  1  sticky flag, set when a divide is rejected for a zero divisor.
REQ-013 Port hi_out  output  32  HI register (remainder).
REQ-014 Port lo_out  output  32  LO register (quotient).

Function
REQ-015 FSM states: IDLE, WAIT, WRITE; encoded state register, reset state IDLE.
REQ-016 IDLE, start=1, divisor!=0: latch dividend/divisor into operand registers, load cycle counter with DIV_CYCLES-1, go to WAIT, busy=1 from the next cycle.
REQ-017 IDLE, start=1, divisor==0: no operand latch, HI/LO unchanged, set div_by_zero, pulse done the next cycle, stay IDLE.
REQ-018 WAIT: decrement counter each cycle; at count 0 go to WRITE.
REQ-019 WRITE: capture divider quotient into LO and remainder into HI unmodified, pulse done in the same cycle, clear busy, return to IDLE.
REQ-020 Latency: start accepted at edge N -> done high in cycle N+DIV_CYCLES+1 -> HI/LO new values visible from that cycle.
REQ-021 The divider core is fed only from the operand registers, never directly from the input ports.
REQ-022 start while busy=1 is ignored; no queuing.
REQ-023 hi_we/lo_we honoured only in IDLE; ignored while busy=1.
REQ-024 hi_we/lo_we with an accepted start in the same IDLE cycle: direct write takes effect, later overwritten by WRITE.
REQ-025 div_by_zero clears on the next accepted non-zero divide; otherwise it holds.
REQ-026 done is never high for two consecutive cycles.

Reset
REQ-027 resetn low at any time, including mid-divide: state=IDLE, counter=0, operands=0, hi_out=0, lo_out=0, busy=0, done=0, div_by_zero=0.
REQ-028 An in-flight divide aborted by reset produces no done pulse and no HI/LO update after release.

Structure
REQ-029 A shared package holds the FSM state encoding constants and the 32-bit data width constant.
REQ-030 Exactly one sub-module: the team's combinational signed divider nonRestoringDivisionPosiNeg, instantiated once, driven by the operand registers.

Verification
REQ-031 resetn low, then high; start with 100 and 7 -> done in cycle N+5 (DIV_CYCLES=4), lo_out=14, hi_out=2, busy high for 4 cycles.
REQ-032 start with 0x7FFFFFFF and 1 -> lo_out=0x7FFFFFFF, hi_out=0, div_by_zero=0.
REQ-033 lo_we=1 with wr_data=0xA5A5A5A5, then start with 9 and 0 -> done next cycle, div_by_zero=1, lo_out stays 0xA5A5A5A5, busy never high.
REQ-034 start with 50 and 8, then start/hi_we pulses during busy -> ignored; result lo_out=6, hi_out=2, single done pulse.
REQ-035 start with 100 and 7, resetn low two cycles later -> all outputs 0, no done pulse after release.
REQ-036 DIV_CYCLES=1 build: start with 21 and 4 -> done in cycle N+2, lo_out=5, hi_out=1.

Source files
------------

// File: rtl/div_hilo_pkg.sv
// Shared definitions for the HI/LO divide unit: data width and FSM state encoding.
package div_hilo_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/div_hilo_unit_divider.sv
// Combinational signed divider (truncating toward zero, remainder takes the
// dividend's sign) built on an unsigned non-restoring array.
module nonRestoringDivisionPosiNeg
  import div_hilo_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] quo;

  assign a_neg = dividend[DATA_W-1];
  assign b_neg = divisor[DATA_W-1];
  assign a_abs = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_abs = b_neg ? (~divisor + 1'b1) : divisor;

  // NOTE: rem/quo are rewritten step by step inside one evaluation, so blocking
  // assignments are required here; every variable gets a default first so no latch forms.
  always_comb begin
    rem = '0;
    quo = a_abs;
    for (int i = 0; i < DATA_W; i++) begin
      // A negative partial remainder is repaired by adding instead of subtracting.
      if (!rem[DATA_W]) rem = {rem[DATA_W-1:0], quo[DATA_W-1]} - {1'b0, b_abs};
      else              rem = {rem[DATA_W-1:0], quo[DATA_W-1]} + {1'b0, b_abs};
      quo = {quo[DATA_W-2:0], ~rem[DATA_W]};
    end
    if (rem[DATA_W]) rem = rem + {1'b0, b_abs};
  end

  assign quotient  = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
  assign remainder = a_neg ? (~rem[DATA_W-1:0] + 1'b1) : rem[DATA_W-1:0];

endmodule

// File: rtl/div_hilo_unit.sv
// HI/LO register pair with a multi-cycle signed divide: quotient lands in LO,
// remainder in HI, after DIV_CYCLES wait cycles on the combinational divider.
module div_hilo_unit
  import div_hilo_pkg::*;
#(
  parameter int DIV_CYCLES = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam logic [3:0] CNT_INIT = 4'(DIV_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  // The divider sees only the latched operands, so port changes mid-divide are harmless.
  nonRestoringDivisionPosiNeg u_div (
    .dividend  (op_a),
    .divisor   (op_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi_out <= wr_data;
          if (lo_we) lo_out <= wr_data;
          if (start && (divisor != '0)) begin
            op_a        <= dividend;
            op_b        <= divisor;
            cnt         <= CNT_INIT;
            div_by_zero <= 1'b0;
            state       <= S_WAIT;
          end else if (start && !done) begin
            // Gating on done keeps a held zero-divide start from pulsing done back to back.
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end
        end
        S_WAIT: begin
          busy <= 1'b1;
          if (cnt == '0) state <= S_WRITE;
          else           cnt   <= cnt - 1'b1;
        end
        S_WRITE: begin
          lo_out <= quotient;
          hi_out <= remainder;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
